// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI transmitter slice.
// Entry format pushed by the game/init logic is {dc, data}.
package oled_pkg;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int CLK_DIV_DEFAULT    = 5;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } oled_entry_t;

  // Divider counter width: enough to hold CLK_DIV-1, never narrower than 1 bit.
  function automatic int div_cnt_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/oled_byte_fifo.sv
// Small synchronous FIFO for {dc, byte} entries. Pointers carry an extra wrap bit
// for full/empty; the empty flag is registered, so a new entry is seen one cycle late.
module oled_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty_q;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = empty_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Compare against the old write pointer: a pop that drains the FIFO
      // shows empty at once, a fresh push becomes visible one cycle later.
      empty_q  <= (rd_ptr_d == wr_ptr_q);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/oled_spi_tx.sv
// Byte-level SPI transmitter for the OLED panel: queues {dc, byte} entries and
// shifts each one out MSB-first with cs framing every byte.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_dc,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       mosi,
  output logic       sck,
  output logic       cs,
  output logic       dc
);

  localparam int                DIV_W   = div_cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

  spi_state_t       state_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [6:0]       shift_q;
  logic             cs_q, sck_q, mosi_q, dc_q;
  logic             busy_q, busy_d;
  logic             push_q;

  oled_entry_t fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        push_fire, div_done, idle_next;

  assign in_ready  = !reset && !fifo_full;
  assign push_fire = in_valid && in_ready;
  assign fifo_din  = '{dc: in_dc, data: in_data};
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign div_done  = (div_q == '0);

  oled_byte_fifo #(
    .WIDTH ($bits(oled_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_fire),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The FSM lands in IDLE next cycle either by staying put with nothing
  // queued or by finishing the inter-byte gap.
  assign idle_next = ((state_q == IDLE) && fifo_empty) ||
                     ((state_q == GAP) && div_done);

  // push_q covers the cycle where a just-pushed entry is not yet visible.
  assign busy_d = push_fire || push_q || !fifo_empty || !idle_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= DIV_MAX;
      bit_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= DC_CMD;
      busy_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      push_q <= push_fire;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_dout.data[6:0];
            mosi_q  <= fifo_dout.data[7];
            dc_q    <= fifo_dout.dc;
            cs_q    <= 1'b0;
            sck_q   <= 1'b1;
            bit_q   <= '0;
            div_q   <= DIV_MAX;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (div_done) begin
            sck_q   <= 1'b0;
            div_q   <= DIV_MAX;
            state_q <= LOW;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        LOW: begin
          if (div_done) begin
            sck_q   <= 1'b1;
            div_q   <= DIV_MAX;
            state_q <= HIGH;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        HIGH: begin
          if (div_done) begin
            div_q <= DIV_MAX;
            if (bit_q != 3'd7) begin
              // Next bit is presented on the falling edge of sck.
              bit_q   <= bit_q + 3'd1;
              mosi_q  <= shift_q[6];
              shift_q <= {shift_q[5:0], 1'b0};
              sck_q   <= 1'b0;
              state_q <= LOW;
            end else begin
              cs_q    <= 1'b1;
              mosi_q  <= 1'b0;
              state_q <= GAP;
            end
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        GAP: begin
          if (div_done) begin
            div_q   <= DIV_MAX;
            state_q <= IDLE;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_q    <= 1'b1;
          sck_q   <= 1'b1;
          div_q   <= DIV_MAX;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign mosi = mosi_q;
  assign sck  = sck_q;
  assign cs   = cs_q;
  assign dc   = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Self-checking bench for oled_spi_tx: decodes the SPI pins into bytes and
// compares them with directed tables and a randomized entry-queue model.
module tb_oled_spi_tx;
  import oled_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CS_LOW     = 17 * CLK_DIV;
  localparam int PERIOD     = 18 * CLK_DIV + 1;

  logic       clk, reset, in_valid, in_ready, in_dc;
  logic [7:0] in_data;
  logic       busy, mosi, sck, cs, dc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  oled_spi_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dc    (in_dc),
    .in_data  (in_data),
    .busy     (busy),
    .mosi     (mosi),
    .sck      (sck),
    .cs       (cs),
    .dc       (dc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required finish", cyc);
    $fatal(1);
  end

  // ---------------- bus monitor: pins -> byte records ----------------
  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         nbits;
    int         low_len;
    bit         dc_chg;
    bit         mosi_chg;
    int         fall_edge;
    int         rise_edge;
    int         first_fall;
  } obs_t;

  obs_t obs_q[$];
  obs_t cur;
  logic prev_cs = 1'b1, prev_sck = 1'b1, prev_busy = 1'b0, prev_mosi = 1'b0;
  int   idle_toggles = 0, sck_rises = 0, cs_falls = 0, busy_fall_edge = -1;

  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      cur = '{dc: dc, data: 8'h00, nbits: 0, low_len: 0, dc_chg: 1'b0, mosi_chg: 1'b0,
              fall_edge: cyc, rise_edge: -1, first_fall: -1};
      cs_falls++;
    end
    if (!cs) begin
      cur.low_len++;
      if (dc !== cur.dc) cur.dc_chg = 1'b1;
      if (!prev_sck && sck) begin
        cur.data = {cur.data[6:0], mosi};
        cur.nbits++;
        sck_rises++;
      end
      if (prev_sck && !sck && cur.first_fall < 0) cur.first_fall = cyc;
      if (!prev_cs && prev_sck && sck && (mosi !== prev_mosi)) cur.mosi_chg = 1'b1;
    end else if (sck !== prev_sck) begin
      idle_toggles++;
    end
    if (!prev_cs && cs) begin
      cur.rise_edge = cyc;
      obs_q.push_back(cur);
    end
    if (prev_busy && !busy) busy_fall_edge = cyc;
    prev_cs   = cs;
    prev_sck  = sck;
    prev_busy = busy;
    prev_mosi = mosi;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Called right after a negedge; returns the edge index at which the push lands.
  task automatic push(input logic d, input logic [7:0] b, output int edge_n, output int waited);
    in_valid = 1'b1;
    in_dc    = d;
    in_data  = b;
    waited   = 0;
    edge_n   = -1;
    while (waited < 500 && !in_ready) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("push_accept_%02h", b), in_ready, 1'b1);
    edge_n = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (!busy && cs) done = 1;
    end
    check({name, "_reaches_idle"}, done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_byte(input string name, input obs_t o, input logic exp_dc,
                            input logic [7:0] exp_data);
    check({name, "_data"}, o.data, exp_data);
    check({name, "_dc"}, o.dc, exp_dc);
    check({name, "_nbits"}, o.nbits, 8);
    check({name, "_cs_low_len"}, o.low_len, CS_LOW);
    check({name, "_dc_stable"}, o.dc_chg, 1'b0);
    check({name, "_mosi_stable_sck_high"}, o.mosi_chg, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       in_dc;
    logic [7:0] in_data;
    logic       exp_dc;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t        vecs[5];
  oled_entry_t exp_q[$];

  initial begin
    int n, w, bad, stall_at, busy_seen, rises0, falls0;
    int edges[6];
    obs_t o;
    logic       rd;
    logic [7:0] rb;

    vecs[0] = '{1'b0, 8'hAF, DC_CMD,  8'hAF};
    vecs[1] = '{1'b1, 8'h00, DC_DATA, 8'h00};
    vecs[2] = '{1'b0, 8'h80, DC_CMD,  8'h80};
    vecs[3] = '{1'b1, 8'h01, DC_DATA, 8'h01};
    vecs[4] = '{1'b1, 8'h5A, DC_DATA, 8'h5A};

    reset = 1'b1; in_valid = 1'b0; in_dc = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1'b1);
    check("rst_sck", sck, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    check("rst_dc", dc, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    // Idle quiet
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sck !== 1'b1 || cs !== 1'b1 || mosi !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
        bad++;
    end
    check("idle_quiet_bad_cycles", bad, 0);

    // Single bytes from idle: content, framing and latency
    foreach (vecs[i]) begin
      obs_q.delete();
      push(vecs[i].in_dc, vecs[i].in_data, n, w);
      check($sformatf("vec%0d_no_stall", i), w, 0);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_nbytes", i), obs_q.size(), 1);
      if (obs_q.size() > 0) begin
        o = obs_q[0];
        check_byte($sformatf("vec%0d", i), o, vecs[i].exp_dc, vecs[i].exp_byte);
        check($sformatf("vec%0d_cs_fall_latency", i), o.fall_edge - n, 2);
        check($sformatf("vec%0d_first_sck_fall", i), o.first_fall - n, 2 + CLK_DIV);
        check($sformatf("vec%0d_busy_after_cs", i), busy_fall_edge - o.rise_edge, CLK_DIV);
      end
    end

    // Mixed dc, back to back
    obs_q.delete();
    push(DC_CMD, 8'hAE, n, w);
    push(DC_DATA, 8'hFF, n, w);
    push(DC_CMD, 8'h8D, n, w);
    wait_idle("mixed");
    check("mixed_nbytes", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check_byte("mixed0", obs_q[0], DC_CMD, 8'hAE);
      check_byte("mixed1", obs_q[1], DC_DATA, 8'hFF);
      check_byte("mixed2", obs_q[2], DC_CMD, 8'h8D);
      check("mixed_period", obs_q[1].fall_edge - obs_q[0].fall_edge, PERIOD);
    end

    // Burst of 6 with in_valid held: the FIFO fills and in_ready drops
    obs_q.delete();
    stall_at = -1;
    for (int i = 0; i < 6; i++) begin
      push(DC_DATA, 8'(i + 1), edges[i], w);
      if (w > 0 && stall_at < 0) stall_at = i;
    end
    check("burst_first_stall_index", stall_at, FIFO_DEPTH + 1);
    wait_idle("burst");
    check("burst_nbytes", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("burst%0d_data", i), obs_q[i].data, 8'(i + 1));
        check($sformatf("burst%0d_nbits", i), obs_q[i].nbits, 8);
        if (i > 0)
          check($sformatf("burst%0d_period", i), obs_q[i].fall_edge - obs_q[i-1].fall_edge, PERIOD);
      end
    end

    // Randomized traffic against an in-order entry queue model
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      rd = 1'($urandom_range(0, 1));
      rb = 8'($urandom_range(0, 255));
      push(rd, rb, n, w);
      exp_q.push_back('{dc: rd, data: rb});
    end
    wait_idle("rand");
    check("rand_nbytes", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_byte($sformatf("rand%0d", i), obs_q[i], exp_q[i].dc, exp_q[i].data);

    check("sck_toggle_while_cs_high", idle_toggles, 0);

    // Reset mid-byte with two entries still queued
    obs_q.delete();
    push(DC_CMD, 8'hC3, n, w);
    push(DC_DATA, 8'h5A, n, w);
    push(DC_CMD, 8'h3C, n, w);
    bad = 1;
    for (int t = 0; t < 500 && bad; t++) begin
      @(negedge clk);
      #1;
      if (!cs && cur.nbits == 3) bad = 0;
    end
    check("midbyte_reached_third_rise", bad, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs", cs, 1'b1);
    check("midrst_sck", sck, 1'b1);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1'b1);
    rises0 = sck_rises;
    falls0 = cs_falls;
    busy_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("midrst_no_more_sck", sck_rises - rises0, 0);
    check("midrst_no_more_cs", cs_falls - falls0, 0);
    check("midrst_busy_stays_low", busy_seen, 0);
    check("midrst_one_partial", obs_q.size(), 1);
    if (obs_q.size() > 0) check("midrst_partial_bits", obs_q[0].nbits, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
